// File: rtl/sample_iterator.sv
// Walks a grid-aligned bounding box on the sample grid, emitting SAMPS adjacent
// sample positions per cycle and holding off upstream while a box is in flight.
module sample_iterator #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int SAMPS  = 4
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]  tri_R13S,
  input  logic        [COLORS-1:0][SIGFIG-1:0]           color_R13U,
  input  logic signed [1:0][1:0][SIGFIG-1:0]             box_R13S,
  input  logic                                           validTri_R13H,
  input  logic        [3:0]                              subSample_RnnnnU,
  output logic                                           halt_RnnnnnL,
  output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]  tri_R14S,
  output logic        [COLORS-1:0][SIGFIG-1:0]           color_R14U,
  output logic signed [1:0][SAMPS-1:0][SIGFIG-1:0]       sample_R14S,
  output logic        [SAMPS-1:0]                        validSamp_R14H
);

  localparam int W         = SIGFIG + 1;
  localparam int GRP_SHIFT = $clog2(SAMPS);

  localparam logic ST_WAIT = 1'b0;
  localparam logic ST_TEST = 1'b1;

  logic                                          state_q,  state_d;
  logic signed [W-1:0]                           x_q,      x_d;
  logic signed [W-1:0]                           y_q,      y_d;
  logic signed [W-1:0]                           ll_x_q,   ll_x_d;
  logic signed [W-1:0]                           ur_x_q,   ur_x_d;
  logic signed [W-1:0]                           ur_y_q,   ur_y_d;
  logic signed [W-1:0]                           step_q,   step_d;
  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q,    tri_d;
  logic        [COLORS-1:0][SIGFIG-1:0]          color_q,  color_d;
  logic signed [1:0][SAMPS-1:0][SIGFIG-1:0]      sample_q, sample_d;
  logic        [SAMPS-1:0]                       valid_q,  valid_d;

  logic signed [W-1:0] in_ll_x, in_ll_y, in_ur_x, in_ur_y;
  logic signed [W-1:0] grp_step;

  // One extra bit of headroom so ur + SAMPS*step never wraps in compares.
  function automatic logic signed [W-1:0] sext(input logic [SIGFIG-1:0] v);
    return $signed({v[SIGFIG-1], v});
  endfunction

  function automatic logic signed [W-1:0] step_of(input logic [3:0] ss);
    logic signed [W-1:0] s;
    s = '0;
    case (ss)
      4'b0100: s[RADIX-1] = 1'b1;
      4'b0010: s[RADIX-2] = 1'b1;
      4'b0001: s[RADIX-3] = 1'b1;
      default: s[RADIX]   = 1'b1;
    endcase
    return s;
  endfunction

  assign in_ll_x  = sext(box_R13S[0][0]);
  assign in_ll_y  = sext(box_R13S[0][1]);
  assign in_ur_x  = sext(box_R13S[1][0]);
  assign in_ur_y  = sext(box_R13S[1][1]);
  assign grp_step = step_q <<< GRP_SHIFT;

  always_comb begin
    logic signed [W-1:0] off;
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    ll_x_d   = ll_x_q;
    ur_x_d   = ur_x_q;
    ur_y_d   = ur_y_q;
    step_d   = step_q;
    tri_d    = tri_q;
    color_d  = color_q;
    sample_d = sample_q;
    valid_d  = '0;
    off      = '0;

    case (state_q)
      ST_WAIT: begin
        if (validTri_R13H) begin
          tri_d   = tri_R13S;
          color_d = color_R13U;
          ll_x_d  = in_ll_x;
          ur_x_d  = in_ur_x;
          ur_y_d  = in_ur_y;
          step_d  = step_of(subSample_RnnnnU);
          x_d     = in_ll_x;
          y_d     = in_ll_y;
          // An empty box is consumed here and never walked.
          if (!(in_ll_x > in_ur_x || in_ll_y > in_ur_y)) state_d = ST_TEST;
        end
      end
      default: begin
        for (int i = 0; i < SAMPS; i++) begin
          sample_d[0][i] = SIGFIG'(x_q + off);
          sample_d[1][i] = SIGFIG'(y_q);
          valid_d[i]     = (x_q + off) <= ur_x_q;
          off            = off + step_q;
        end
        if (x_q + grp_step <= ur_x_q) begin
          x_d = x_q + grp_step;
        end else begin
          x_d = ll_x_q;
          y_d = y_q + step_q;
          if (y_q + step_q > ur_y_q) state_d = ST_WAIT;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_WAIT;
      x_q      <= '0;
      y_q      <= '0;
      ll_x_q   <= '0;
      ur_x_q   <= '0;
      ur_y_q   <= '0;
      step_q   <= '0;
      tri_q    <= '0;
      color_q  <= '0;
      sample_q <= '0;
      valid_q  <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      ll_x_q   <= ll_x_d;
      ur_x_q   <= ur_x_d;
      ur_y_q   <= ur_y_d;
      step_q   <= step_d;
      tri_q    <= tri_d;
      color_q  <= color_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end

  assign halt_RnnnnnL   = (state_q == ST_WAIT);
  assign tri_R14S       = tri_q;
  assign color_R14U     = color_q;
  assign sample_R14S    = sample_q;
  assign validSamp_R14H = valid_q;

endmodule

// File: tb/tb_sample_iterator.sv
// Directed table-driven bench for sample_iterator: box walks, lane masks,
// back-to-back accepts, empty boxes and asynchronous reset mid-walk.
module tb_sample_iterator;

  localparam int SIGFIG = 24;
  localparam int RADIX  = 10;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;
  localparam int SAMPS  = 4;
  localparam int TRI_W  = VERTS * AXIS * SIGFIG;
  localparam int COL_W  = COLORS * SIGFIG;

  logic                                          clk = 1'b0;
  logic                                          rst;
  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S;
  logic        [COLORS-1:0][SIGFIG-1:0]          color_R13U;
  logic signed [1:0][1:0][SIGFIG-1:0]            box_R13S;
  logic                                          validTri_R13H;
  logic        [3:0]                             subSample_RnnnnU;
  logic                                          halt_RnnnnnL;
  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S;
  logic        [COLORS-1:0][SIGFIG-1:0]          color_R14U;
  logic signed [1:0][SAMPS-1:0][SIGFIG-1:0]      sample_R14S;
  logic        [SAMPS-1:0]                       validSamp_R14H;

  sample_iterator #(
    .SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS),
    .AXIS(AXIS), .COLORS(COLORS), .SAMPS(SAMPS)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .tri_R13S         (tri_R13S),
    .color_R13U       (color_R13U),
    .box_R13S         (box_R13S),
    .validTri_R13H    (validTri_R13H),
    .subSample_RnnnnU (subSample_RnnnnU),
    .halt_RnnnnnL     (halt_RnnnnnL),
    .tri_R14S         (tri_R14S),
    .color_R14U       (color_R14U),
    .sample_R14S      (sample_R14S),
    .validSamp_R14H   (validSamp_R14H)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [31:0]       llx, lly, urx, ury;
    logic        [3:0]        sub;
    logic signed [31:0]       step;
    int                       ng;
    logic signed [3:0][31:0]  gx;
    logic signed [3:0][31:0]  gy;
    logic        [3:0][3:0]   gv;
  } vec_t;

  localparam int NCASES = 6;
  vec_t tbl [NCASES];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [TRI_W-1:0] mk_tri(input int seed);
    logic [TRI_W-1:0] r;
    r = '0;
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++)
        r[(v*AXIS+a)*SIGFIG +: SIGFIG] = SIGFIG'(seed*100 + v*10 + a);
    return r;
  endfunction

  function automatic logic [COL_W-1:0] mk_col(input int seed);
    logic [COL_W-1:0] r;
    r = '0;
    for (int c = 0; c < COLORS; c++)
      r[c*SIGFIG +: SIGFIG] = SIGFIG'(seed*1000 + 7*c + 3);
    return r;
  endfunction

  task automatic set_case(input int idx, input int llx, input int lly, input int urx,
                          input int ury, input logic [3:0] sub, input int step, input int ng);
    tbl[idx].llx  = llx;
    tbl[idx].lly  = lly;
    tbl[idx].urx  = urx;
    tbl[idx].ury  = ury;
    tbl[idx].sub  = sub;
    tbl[idx].step = step;
    tbl[idx].ng   = ng;
    tbl[idx].gx   = '0;
    tbl[idx].gy   = '0;
    tbl[idx].gv   = '0;
  endtask

  task automatic set_grp(input int idx, input int g, input int x0, input int y, input logic [3:0] v);
    tbl[idx].gx[g] = x0;
    tbl[idx].gy[g] = y;
    tbl[idx].gv[g] = v;
  endtask

  task automatic drive_box(input int llx, input int lly, input int urx, input int ury,
                           input logic [3:0] sub, input int seed);
    logic [31:0] t;
    t = llx; box_R13S[0][0] = t[SIGFIG-1:0];
    t = lly; box_R13S[0][1] = t[SIGFIG-1:0];
    t = urx; box_R13S[1][0] = t[SIGFIG-1:0];
    t = ury; box_R13S[1][1] = t[SIGFIG-1:0];
    subSample_RnnnnU = sub;
    tri_R13S   = mk_tri(seed);
    color_R13U = mk_col(seed);
  endtask

  task automatic check_group(input string tag, input logic signed [31:0] x0,
                             input logic signed [31:0] y, input logic signed [31:0] step,
                             input logic [3:0] v);
    logic [SIGFIG-1:0] ex;
    logic [SIGFIG-1:0] ey;
    logic [31:0]       t;
    t  = y;
    ey = t[SIGFIG-1:0];
    for (int i = 0; i < SAMPS; i++) begin
      t  = x0 + i * step;
      ex = t[SIGFIG-1:0];
      check($sformatf("%s lane%0d_x", tag, i), sample_R14S[0][i], ex);
      check($sformatf("%s lane%0d_y", tag, i), sample_R14S[1][i], ey);
    end
    check($sformatf("%s valid", tag), validSamp_R14H, v);
  endtask

  task automatic run_case(input int idx);
    vec_t c;
    c = tbl[idx];
    @(posedge clk); #1;
    drive_box(c.llx, c.lly, c.urx, c.ury, c.sub, idx + 1);
    validTri_R13H = 1'b1;
    @(posedge clk); #1;
    validTri_R13H = 1'b0;
    @(negedge clk);
    check($sformatf("case%0d halt_after_accept", idx), halt_RnnnnnL, 1'b0);
    check($sformatf("case%0d tri_latched", idx), tri_R14S, mk_tri(idx + 1));
    for (int g = 0; g < c.ng; g++) begin
      @(negedge clk);
      check_group($sformatf("case%0d grp%0d", idx, g), c.gx[g], c.gy[g], c.step, c.gv[g]);
      check($sformatf("case%0d grp%0d halt", idx, g), halt_RnnnnnL, (g + 1 < c.ng) ? 1'b0 : 1'b1);
      check($sformatf("case%0d grp%0d tri", idx, g), tri_R14S, mk_tri(idx + 1));
      check($sformatf("case%0d grp%0d color", idx, g), color_R14U, mk_col(idx + 1));
    end
    @(negedge clk);
    check($sformatf("case%0d idle_valid", idx), validSamp_R14H, 4'b0000);
    check($sformatf("case%0d idle_halt", idx), halt_RnnnnnL, 1'b1);
  endtask

  // Back-to-back expectations, one entry per edge starting at the first accept.
  logic       b2b_halt  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [3:0] b2b_valid [6] = '{4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0001, 4'b0000};

  initial begin
    set_case(0, 0, 0, 3072, 1024, 4'b1000, 1024, 2);
    set_grp (0, 0, 0, 0,    4'b1111);
    set_grp (0, 1, 0, 1024, 4'b1111);

    set_case(1, 0, 0, 4096, 0, 4'b1000, 1024, 2);
    set_grp (1, 0, 0,    0, 4'b1111);
    set_grp (1, 1, 4096, 0, 4'b0001);

    set_case(2, 256, 512, 1024, 512, 4'b0010, 256, 1);
    set_grp (2, 0, 256, 512, 4'b1111);

    set_case(3, -2048, 3072, -2048, 3072, 4'b1000, 1024, 1);
    set_grp (3, 0, -2048, 3072, 4'b0001);

    set_case(4, 0, 0, 2560, 512, 4'b0100, 512, 4);
    set_grp (4, 0, 0,    0,   4'b1111);
    set_grp (4, 1, 2048, 0,   4'b0011);
    set_grp (4, 2, 0,    512, 4'b1111);
    set_grp (4, 3, 2048, 512, 4'b0011);

    set_case(5, -128, -128, 256, -128, 4'b0001, 128, 1);
    set_grp (5, 0, -128, -128, 4'b1111);

    rst = 1'b0;
    validTri_R13H = 1'b0;
    drive_box(0, 0, 0, 0, 4'b1000, 0);
    #1;
    check("reset halt",   halt_RnnnnnL,   1'b1);
    check("reset valid",  validSamp_R14H, 4'b0000);
    check("reset sample", sample_R14S,    '0);
    check("reset tri",    tri_R14S,       '0);
    check("reset color",  color_R14U,     '0);
    @(posedge clk); #2;
    rst = 1'b1;

    for (int k = 0; k < NCASES; k++) run_case(k);

    // Empty boxes are consumed without a walk.
    @(posedge clk); #1;
    drive_box(2048, 0, 1024, 0, 4'b1000, 40);
    validTri_R13H = 1'b1;
    @(posedge clk); #1;
    drive_box(0, 1024, 0, 0, 4'b1000, 41);
    @(posedge clk); #1;
    validTri_R13H = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("empty%0d halt", k),  halt_RnnnnnL,   1'b1);
      check($sformatf("empty%0d valid", k), validSamp_R14H, 4'b0000);
    end

    // Back-to-back: second triangle waits while the first walks two rows.
    @(posedge clk); #1;
    drive_box(0, 0, 3072, 1024, 4'b1000, 50);
    validTri_R13H = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (k == 0) drive_box(1024, 1024, 1024, 1024, 4'b1000, 51);
      if (k == 3) validTri_R13H = 1'b0;
      @(negedge clk);
      check($sformatf("b2b%0d halt", k),  halt_RnnnnnL,   b2b_halt[k]);
      check($sformatf("b2b%0d valid", k), validSamp_R14H, b2b_valid[k]);
      check($sformatf("b2b%0d tri", k),   tri_R14S,   (k < 3) ? mk_tri(50) : mk_tri(51));
      check($sformatf("b2b%0d color", k), color_R14U, (k < 3) ? mk_col(50) : mk_col(51));
      if (k == 2) check_group("b2b first_row2", 0, 1024, 1024, 4'b1111);
      if (k == 4) check_group("b2b second", 1024, 1024, 1024, 4'b0001);
    end

    // Reset in the middle of a walk abandons the box at once.
    @(posedge clk); #1;
    drive_box(0, 0, 3072, 1024, 4'b1000, 60);
    validTri_R13H = 1'b1;
    @(posedge clk); #1;
    validTri_R13H = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midwalk valid_before_reset", validSamp_R14H, 4'b1111);
    #2 rst = 1'b0;
    #1;
    check("midwalk reset halt",   halt_RnnnnnL,   1'b1);
    check("midwalk reset valid",  validSamp_R14H, 4'b0000);
    check("midwalk reset sample", sample_R14S,    '0);
    check("midwalk reset tri",    tri_R14S,       '0);
    @(posedge clk); #2;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("post_reset%0d halt", k),  halt_RnnnnnL,   1'b1);
      check($sformatf("post_reset%0d valid", k), validSamp_R14H, 4'b0000);
    end
    run_case(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_iterator.md
# sample_iterator

Rasterizer stage directly upstream of the sample test stage. Accepts one bounding-boxed triangle at a time and walks its box on the sample grid, left-to-right then bottom-to-top, emitting `SAMPS` horizontally adjacent sample positions per cycle with per-lane valid flags. It back-pressures the bounding-box stage with `halt_RnnnnnL` while a box is being walked, and forwards triangle and color alongside each sample group.

## Interface

**Parameters**
- `SIGFIG` (24): bits in position and color.
- `RADIX` (10): fraction bits in position.
- `VERTS` (3): vertices per triangle.
- `AXIS` (3): axes per vertex (x, y, z).
- `COLORS` (3): color channels.
- `SAMPS` (4): sample lanes emitted per cycle; power of two, at most 8.

**Ports**
- `clk` in 1: clock. One clock.
- `rst` in 1: reset, asynchronous, active-low.
- `tri_R13S` in `[VERTS][AXIS]` × `SIGFIG` signed: triangle.
- `color_R13U` in `[COLORS]` × `SIGFIG`: triangle color.
- `box_R13S` in `[1:0][1:0]` × `SIGFIG` signed: bounding box; `[0]` is lower-left, `[1]` is upper-right, `[.][0]` is x, `[.][1]` is y. Grid-aligned by upstream.
- `validTri_R13H` in 1: input triangle valid.
- `subSample_RnnnnU` in 4: one-hot sample spacing. 1000 = 1 px, 0100 = 1/2, 0010 = 1/4, 0001 = 1/8.
- `halt_RnnnnnL` out 1: low means the block is busy and upstream must hold.
- `tri_R14S` out, same shape as `tri_R13S`: latched triangle.
- `color_R14U` out `[COLORS]` × `SIGFIG`: latched color.
- `sample_R14S` out `[1:0][SAMPS]` × `SIGFIG` signed: lane x/y positions.
- `validSamp_R14H` out `[SAMPS]` × 1: lane valid.

## Operation

**Step size**
- `step = 1 << (RADIX - k)`, where k = 0, 1, 2, 3 for 1000, 0100, 0010, 0001.
- `subSample_RnnnnU` is quasi-static: it is sampled at triangle accept and held for the whole box.

**State machine**
- States: `WAIT`, `TEST`.

**WAIT**
- `halt_RnnnnnL` = 1.
- On `validTri_R13H` = 1:
  - Latch `tri`, `color`, `box`, `step`.
  - Set cursor (x, y) to lower-left.
  - Go to `TEST`.
- Empty box (ll.x > ur.x or ll.y > ur.y): the triangle is consumed and dropped, state stays `WAIT`, and no valid samples are emitted.

**TEST**
- `halt_RnnnnnL` = 0.
- Each cycle, lane i position = (x + i·step, y).
- Lane i valid iff x + i·step ≤ ur.x.
- Advance:
  - If x + SAMPS·step ≤ ur.x: x += SAMPS·step.
  - Otherwise: x = ll.x and y += step.
  - If the new y > ur.y: go to `WAIT`. The current group is the last one.
- Upstream inputs are ignored in `TEST`.

**Arithmetic**
- All cursor adds and compares are signed on `SIGFIG+1` bits, so ur + SAMPS·step cannot wrap.
- Emitted positions are truncated to `SIGFIG` bits.

**Output registers**
- All R14 outputs are registered.
- `validSamp_R14H` = 0 on every cycle where the state register was `WAIT`.
- `tri_R14S` and `color_R14U` hold the last latched triangle and change only at accept.

## Timing

**Reset** (`rst` = 0, asynchronous)
- State `WAIT`, so `halt_RnnnnnL` = 1.
- All `validSamp_R14H` = 0.
- `sample_R14S`, `tri_R14S`, `color_R14U` = 0.
- Cursor and latched box = 0.
- Asserting reset mid-walk abandons the box immediately. The first cycle after release is `WAIT` with no stale valids.

**Latency and throughput**
- Accept at edge E.
- `halt_RnnnnnL` falls after E, derived combinationally from the state register.
- The first sample group appears on R14 at edge E+1.
- Each group takes one cycle.
- A box of G groups holds `halt_RnnnnnL` low for G cycles.
- After the last group the block returns to `WAIT`, so there is one ready cycle (bubble) before the next accept.

**Handshake**
- Upstream holds its R13 inputs whenever `halt_RnnnnnL` = 0.
- A valid triangle presented while `halt_RnnnnnL` = 1 is accepted at that edge.

**Boundaries**
- Single-sample box (ll = ur): exactly one cycle with only lane 0 valid.
- Row width not a multiple of SAMPS: the last group of each row has the trailing lanes invalid.
- When the last group completes and a new valid triangle is waiting, the new triangle is not accepted until the following `WAIT` cycle.

## Test plan

- **Reset:** `rst` = 0 mid-`TEST` → same cycle, `validSamp_R14H` = 0000 and `halt_RnnnnnL` = 1. After release, the next triangle walks from its own lower-left.
- **Full-width box:** SAMPS = 4, RADIX = 10, subSample = 1000, box ll = (0, 0), ur = (3072, 1024).
  - Cycle 1: x = 0/1024/2048/3072, y = 0, valid 1111.
  - Cycle 2: same x, y = 1024, valid 1111.
  - `halt_RnnnnnL` low for exactly 2 cycles.
- **Partial row:** ll = (0, 0), ur = (4096, 0), subSample = 1000.
  - Cycle 1: valid 1111.
  - Cycle 2: x = 4096/5120/6144/7168, valid 0001.
  - Then `WAIT`.
- **Quarter-pixel spacing:** subSample = 0010, ll = (256, 512), ur = (1024, 512).
  - Step = 256.
  - Group 1: x = 256/512/768/1024, valid 1111.
  - One group total.
- **Back-to-back triangles:** `validTri_R13H` held high with two triangles → second accept exactly one cycle after `halt_RnnnnnL` rises. `tri_R14S` and `color_R14U` stay stable throughout the first walk.
- **Degenerate box:** ll = (2048, 0), ur = (1024, 0) → `halt_RnnnnnL` stays 1 and no valid sample is ever emitted.
